wb_write_post_buffer: RTL and testbench
=======================================

Name: wb_write_post_buffer

Overview:
Wishbone write-posting buffer placed between the management-SoC Wishbone port and the user-area BRAM slave. That slave acks only after a fixed multi-cycle delay. This block acks posted writes in one cycle, queues them in a FIFO, and drains them to the slave in order. Reads are forwarded only after all queued writes have retired, so read-after-write ordering is preserved.

Parameters:
DEPTH, 4, FIFO entries, power of two, minimum 2
ADDR_BASE, 8'h38, value that wbs_adr_i[31:24] must match for the access to be claimed
TIMEOUT, 32, downstream cycles allowed without m_ack_i before the access is aborted
ERR_DATA, 32'hDEAD_BEEF, data returned on a timed-out read

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_cyc_i / wbs_stb_i / wbs_we_i  in  1 each  upstream Wishbone cycle, strobe, write enable
wbs_sel_i  in  4  upstream byte selects
wbs_adr_i / wbs_dat_i  in  32 each  upstream address, write data
wbs_ack_o  out  1  upstream acknowledge, one-cycle pulse
wbs_dat_o  out  32  upstream read data, registered
m_cyc_o / m_stb_o / m_we_o  out  1 each  downstream cycle, strobe, write enable
m_sel_o  out  4  downstream byte selects
m_adr_o / m_dat_o  out  32 each  downstream address, write data
m_ack_i  in  1  downstream acknowledge
m_dat_i  in  32  downstream read data
fifo_level_o  out  clog2(DEPTH)+1  current FIFO occupancy
err_o  out  1  sticky timeout flag
err_clr_i  in  1  clears err_o; set wins if coincident

Behaviour:
- Claim condition: req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24]==ADDR_BASE) & !wbs_ack_o. Unclaimed accesses get no ack and cause no action.
- Reset: all outputs 0, FIFO empty, FSM IDLE, and timeout counter 0. Reset mid-operation discards queued writes and abandons any downstream access; m_cyc_o/m_stb_o drop immediately.
- Posted write: req & wbs_we_i & count<DEPTH in cycle N:
  - push {adr, dat, sel} in cycle N;
  - wbs_ack_o=1 in cycle N+1 only.
  - When full, hold with no ack until a pop frees a slot. The push then occurs in the cycle after the pop is registered.
- Simultaneous push and pop with count<DEPTH: both happen and count is unchanged. Pointers wrap modulo DEPTH.
- Drain FSM states: IDLE, WR, RD, RESP.
  - IDLE -> WR when FIFO is not empty. From the next cycle, m_cyc_o=m_stb_o=m_we_o=1 and m_adr_o/m_dat_o/m_sel_o are driven from the FIFO head.
  - IDLE -> RD when FIFO is empty and a read req is pending. From the next cycle, m_cyc_o=m_stb_o=1, m_we_o=0, m_adr_o=wbs_adr_i, m_sel_o=wbs_sel_i. Pending writes always take priority over a read.
  - WR: on m_ack_i, pop the head, deassert m_cyc_o/m_stb_o in the next cycle, and return to IDLE. This gives at least one idle cycle between downstream transactions.
  - RD: on m_ack_i, capture m_dat_i into wbs_dat_o, deassert the downstream strobe, and go to RESP.
  - RESP: wbs_ack_o=1 for one cycle, then go to IDLE. Read latency is downstream latency + 2 cycles.
- Timeout:
  - The counter clears on entry to WR/RD and increments each cycle while waiting.
  - At TIMEOUT with no m_ack_i, the strobe drops and err_o is set.
  - WR timeout: pop and discard the entry.
  - RD timeout: wbs_dat_o=ERR_DATA, then go to RESP.
  - m_ack_i while in IDLE is ignored.
- wbs_dat_o holds its last value between reads. Downstream outputs hold their values while m_stb_o=0 and are don't-care for checking.
- Upstream writes are accepted during any drain state. Upstream reads stall (no ack) while the FIFO is non-empty or the FSM is not IDLE.

Test Plan:
- Single write 0x3800_0010 <= 0x1234_5678, downstream slave acks 10 cycles after stb -> wbs_ack_o pulses 1 cycle after req; m_stb_o asserts with adr 0x3800_0010 / dat 0x1234_5678; fifo_level_o goes 1 -> 0 on m_ack_i.
- Five back-to-back writes with DEPTH=4 and a slow slave -> first four acked at 1-cycle latency; fifth acked only after the first pop; downstream order matches issue order; pointer wrap is exercised.
- Write 0x3800_0020 <= 0xA5A5_A5A5 immediately followed by a read of 0x3800_0020 -> read stalls until the write retires; m_we_o=0 on a later strobe; wbs_dat_o=0xA5A5_A5A5 with ack 2 cycles after m_ack_i.
- Access with adr[31:24]=0x30 -> no wbs_ack_o, no FIFO push, m_cyc_o stays 0.
- Slave never acks, TIMEOUT=32 -> strobe drops after 32 cycles; err_o=1; queued write discarded; a subsequent read returns 0xDEAD_BEEF; err_clr_i pulse -> err_o=0.
- Assert wb_rst_i mid-drain with 3 entries queued -> m_stb_o=0, fifo_level_o=0, wbs_ack_o=0 asynchronously; normal operation resumes after deassertion.

Source files
------------

// File: rtl/wb_write_post_buffer.sv
// Wishbone write-posting buffer: acks writes in one cycle, queues them,
// drains them in order to a slow slave; reads wait for the queue to empty.
module wb_write_post_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  ADDR_BASE = 8'h38,
  parameter int          TIMEOUT   = 32,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [3:0]                wbs_sel_i,
  input  logic [31:0]               wbs_adr_i,
  input  logic [31:0]               wbs_dat_i,
  output logic                      wbs_ack_o,
  output logic [31:0]               wbs_dat_o,
  output logic                      m_cyc_o,
  output logic                      m_stb_o,
  output logic                      m_we_o,
  output logic [3:0]                m_sel_o,
  output logic [31:0]               m_adr_o,
  output logic [31:0]               m_dat_o,
  input  logic                      m_ack_i,
  input  logic [31:0]               m_dat_i,
  output logic [$clog2(DEPTH):0]    fifo_level_o,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    RESP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          req;
  logic          wr_req;
  logic          rd_req;
  logic          push;
  logic          pop;
  logic          start_wr;
  logic          start_rd;
  logic          m_done;
  logic          m_tmo;

  logic [31:0]   mem_adr [DEPTH];
  logic [31:0]   mem_dat [DEPTH];
  logic [3:0]    mem_sel [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tmo_cnt;

  // The ack term keeps a still-held strobe from being claimed twice.
  assign req = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[31:24] == ADDR_BASE) & ~wbs_ack_o;
  assign wr_req = req & wbs_we_i;
  assign rd_req = req & ~wbs_we_i;
  assign push   = wr_req & (count < FULL);

  assign fifo_level_o = count;

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_adr[wr_ptr] <= wbs_adr_i;
      mem_dat[wr_ptr] <= wbs_dat_i;
      mem_sel[wr_ptr] <= wbs_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Queued writes always win over a waiting read.
  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    m_done    = 1'b0;
    m_tmo     = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = WR;
          start_wr  = 1'b1;
        end else if (rd_req) begin
          state_nxt = RD;
          start_rd  = 1'b1;
        end
      end
      WR: begin
        if (m_ack_i) begin
          state_nxt = IDLE;
          m_done    = 1'b1;
          pop       = 1'b1;
        end else if (tmo_cnt == TLAST) begin
          state_nxt = IDLE;
          m_tmo     = 1'b1;
          pop       = 1'b1;
        end
      end
      RD: begin
        if (m_ack_i) begin
          state_nxt = RESP;
          m_done    = 1'b1;
        end else if (tmo_cnt == TLAST) begin
          state_nxt = RESP;
          m_tmo     = 1'b1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
    end else if (start_wr) begin
      m_cyc_o <= 1'b1;
      m_stb_o <= 1'b1;
      m_we_o  <= 1'b1;
      m_sel_o <= mem_sel[rd_ptr];
      m_adr_o <= mem_adr[rd_ptr];
      m_dat_o <= mem_dat[rd_ptr];
    end else if (start_rd) begin
      m_cyc_o <= 1'b1;
      m_stb_o <= 1'b1;
      m_we_o  <= 1'b0;
      m_sel_o <= wbs_sel_i;
      m_adr_o <= wbs_adr_i;
    end else if (m_done | m_tmo) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= push | (state == RESP);
      if (state == RD) begin
        if (m_done)     wbs_dat_o <= m_dat_i;
        else if (m_tmo) wbs_dat_o <= ERR_DATA;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tmo_cnt <= '0;
    end else if (start_wr | start_rd) begin
      tmo_cnt <= '0;
    end else if ((state == WR) || (state == RD)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // A new timeout outranks a coincident clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)       err_o <= 1'b0;
    else if (m_tmo)     err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end

endmodule

// File: tb/tb_wb_write_post_buffer.sv
// Directed bench for wb_write_post_buffer with a delayed-ack slave model.
module tb_wb_write_post_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic        m_ack_i = 1'b0;
  logic [31:0] m_dat_i = '0;
  logic [2:0]  fifo_level_o;
  logic        err_o;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  wb_write_post_buffer dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_cyc_i    (cyc),
    .wbs_stb_i    (stb),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_adr_i    (adr),
    .wbs_dat_i    (dat),
    .wbs_ack_o    (wbs_ack_o),
    .wbs_dat_o    (wbs_dat_o),
    .m_cyc_o      (m_cyc_o),
    .m_stb_o      (m_stb_o),
    .m_we_o       (m_we_o),
    .m_sel_o      (m_sel_o),
    .m_adr_o      (m_adr_o),
    .m_dat_o      (m_dat_o),
    .m_ack_i      (m_ack_i),
    .m_dat_i      (m_dat_i),
    .fifo_level_o (fifo_level_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt++;

  // Slave: acks s_lat cycles after the strobe is first seen.
  int          s_lat     = 10;
  bit          s_never   = 1'b0;
  int          s_cnt     = 0;
  int          s_ack_cyc = 0;
  logic [31:0] s_mem [64];
  logic [31:0] log_adr [$];
  bit          log_we  [$];

  always @(negedge clk) begin
    if (rst) begin
      m_ack_i = 1'b0;
      s_cnt   = 0;
    end else if (m_ack_i) begin
      m_ack_i = 1'b0;
      s_cnt   = 0;
    end else if (m_cyc_o && m_stb_o) begin
      s_cnt++;
      if (!s_never && s_cnt >= s_lat) begin
        m_ack_i   = 1'b1;
        s_ack_cyc = cyc_cnt;
        log_adr.push_back(m_adr_o);
        log_we.push_back(m_we_o);
        if (m_we_o) s_mem[m_adr_o[7:2]] = m_dat_o;
        else        m_dat_i = s_mem[m_adr_o[7:2]];
      end
    end else begin
      s_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = a; dat = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wbs_ack_o && lat < 300);
    if (!wbs_ack_o) check("wr_ack_bound", 32'(wbs_ack_o), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d,
                         output int lat, output int ack_cyc);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
    adr = a;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wbs_ack_o && lat < 300);
    if (!wbs_ack_o) check("rd_ack_bound", 32'(wbs_ack_o), 32'd1);
    d       = wbs_dat_o;
    ack_cyc = cyc_cnt;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_stb();
    int n = 0;
    while (!m_stb_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_stb_o) check("stb_bound", 32'(m_stb_o), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fifo_level_o != 0 || m_cyc_o) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) check("idle_bound", 32'(fifo_level_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          ackc;
    int          base;
    int          n;
    logic [31:0] rd;
    bit          saw_ack;
    bit          saw_cyc;

    foreach (s_mem[i]) s_mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   32'(wbs_ack_o),    32'd0);
    check("rst_dat",   wbs_dat_o,         32'd0);
    check("rst_cyc",   32'(m_cyc_o),      32'd0);
    check("rst_stb",   32'(m_stb_o),      32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_err",   32'(err_o),        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single posted write
    wb_write(32'h3800_0010, 32'h1234_5678, lat);
    check("w1_lat", 32'(lat), 32'd1);
    wait_stb();
    check("w1_adr",   m_adr_o,           32'h3800_0010);
    check("w1_dat",   m_dat_o,           32'h1234_5678);
    check("w1_we",    32'(m_we_o),       32'd1);
    check("w1_lvl1",  32'(fifo_level_o), 32'd1);
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!m_ack_i && n < 100);
    check("w1_slave_ack", 32'(m_ack_i), 32'd1);
    @(posedge clk); #1;
    check("w1_lvl0",  32'(fifo_level_o), 32'd0);
    check("w1_stb0",  32'(m_stb_o),      32'd0);
    wait_idle();

    // five writes into a four-deep queue
    base = log_adr.size();
    for (int i = 0; i < 4; i++) begin
      wb_write(32'h3800_0080 + 32'(4 * i), 32'h1000_0000 + 32'(i), lat);
      check($sformatf("w5_lat%0d", i), 32'(lat), 32'd1);
    end
    check("w5_full", 32'(fifo_level_o), 32'd4);
    wb_write(32'h3800_0090, 32'h1000_0004, lat);
    check("w5_stall", 32'(lat > 1), 32'd1);
    wait_idle();
    check("w5_count", 32'(log_adr.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < log_adr.size())
        check($sformatf("w5_order%0d", i), log_adr[base + i],
              32'h3800_0080 + 32'(4 * i));
    end
    check("w5_mem4", s_mem[36], 32'h1000_0004);

    // read after write
    wb_write(32'h3800_0020, 32'hA5A5_A5A5, lat);
    wb_read(32'h3800_0020, rd, lat, ackc);
    check("raw_data",  rd,                  32'hA5A5_A5A5);
    check("raw_ack2",  32'(ackc - s_ack_cyc), 32'd2);
    check("raw_stall", 32'(lat > 10),       32'd1);
    check("raw_rd_we", 32'(log_we[log_we.size() - 1]), 32'd0);
    check("raw_wr_we", 32'(log_we[log_we.size() - 2]), 32'd1);
    check("raw_rd_adr", log_adr[log_adr.size() - 1], 32'h3800_0020);
    wait_idle();

    // unclaimed access
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h3000_0010; dat = 32'h5555_5555;
    saw_ack = 1'b0;
    saw_cyc = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      saw_ack |= wbs_ack_o;
      saw_cyc |= m_cyc_o;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("unc_ack",   32'(saw_ack),      32'd0);
    check("unc_cyc",   32'(saw_cyc),      32'd0);
    check("unc_level", 32'(fifo_level_o), 32'd0);

    // timeout on a write, then on a read
    s_never = 1'b1;
    base = log_adr.size();
    wb_write(32'h3800_0040, 32'h1111_2222, lat);
    wait_stb();
    n = 0;
    while (m_stb_o && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("tmo_stb_cycles", 32'(n),            32'd32);
    check("tmo_err",        32'(err_o),        32'd1);
    check("tmo_level",      32'(fifo_level_o), 32'd0);
    wb_read(32'h3800_0040, rd, lat, ackc);
    check("tmo_rd_data", rd, 32'hDEAD_BEEF);
    s_never = 1'b0;
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("tmo_err_clr", 32'(err_o), 32'd0);
    wb_read(32'h3800_0040, rd, lat, ackc);
    check("tmo_discarded", rd, 32'd0);
    check("tmo_no_log", 32'(log_adr.size() - base), 32'd1);
    wait_idle();

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++)
      wb_write(32'h3800_00C0 + 32'(4 * i), 32'h7700_0000 + 32'(i), lat);
    check("mr_level3", 32'(fifo_level_o), 32'd3);
    check("mr_stb1",   32'(m_stb_o),      32'd1);
    base = log_adr.size();
    rst = 1'b1;
    #1;
    check("mr_stb",   32'(m_stb_o),      32'd0);
    check("mr_cyc",   32'(m_cyc_o),      32'd0);
    check("mr_level", 32'(fifo_level_o), 32'd0);
    check("mr_ack",   32'(wbs_ack_o),    32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wb_write(32'h3800_0050, 32'hCAFE_F00D, lat);
    check("mr_wr_lat", 32'(lat), 32'd1);
    wb_read(32'h3800_0050, rd, lat, ackc);
    check("mr_rd_data", rd, 32'hCAFE_F00D);
    check("mr_log", 32'(log_adr.size() - base), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
